// File: rtl/bram_rd_pkg.sv
// Shared widths, timeout counter width and FSM state encoding for the
// two-requester BRAM read arbiter.
package bram_rd_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    // Wide enough for the largest supported timeout (255 cycles).
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // One-hot strobe vector for the requester selected by idx.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin grant selection. The pointer names the requester that
// wins a tie; it moves to the other requester only when a grant is taken.
module bram_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic       o_valid,
    output logic       o_grant_idx
);

    logic ptr_q;
    logic ptr_d;
    logic grant_idx;

    // Pick the single active requester, or the pointer's choice on a tie.
    always_comb begin
        grant_idx = 1'b0;
        unique case (i_req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ptr_q;
            default: grant_idx = 1'b0;
        endcase
    end

    // After serving one requester, the other one is preferred next time.
    always_comb begin
        ptr_d = ptr_q;
        if (i_grant_en && (|i_req)) begin
            ptr_d = ~grant_idx;
        end
    end

    // Pointer register; reset prefers requester 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_valid     = |i_req;
    assign o_grant_idx = grant_idx;

endmodule

// File: rtl/bram_rd_arbiter.sv
// Arbitrates two level-sensitive read requesters onto one BRAM read port.
// A read is held (trigger and address constant) until the BRAM reports done
// or a timeout expires; a one-cycle trigger-low RELEASE separates reads.
module bram_rd_arbiter
    import bram_rd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_trig,
    input  logic [DATA_W-1:0] i_bram_data,
    input  logic              i_bram_done,
    output logic              o_busy
);

    // Counter value at which an ISSUE without done is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q;
    logic              gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              trig_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic              busy_q;

    logic [1:0]        req_vec;
    logic [ADDR_W-1:0] addr_vec [2];
    logic              arb_valid;
    logic              arb_idx;
    logic              grant_en;

    // Gather per-requester inputs into vectors for indexed selection.
    assign req_vec     = {i_req1, i_req0};
    assign addr_vec[0] = i_addr0;
    assign addr_vec[1] = i_addr1;

    // Grants are only taken from IDLE, so a request still high while in
    // RELEASE is not re-granted until the trigger has been low for a cycle.
    assign grant_en = (state_q == IDLE);

    bram_rr_arb2 u_arb (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (req_vec),
        .i_grant_en  (grant_en),
        .o_valid     (arb_valid),
        .o_grant_idx (arb_idx)
    );

    // Read-cycle FSM; all outputs are registered and reset asynchronously so
    // the trigger drops the instant reset is applied.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    // i_bram_done is deliberately not looked at here.
                    if (arb_valid && grant_en) begin
                        gnt_q   <= arb_idx;
                        addr_q  <= addr_vec[arb_idx];
                        trig_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Done wins over a timeout landing on the same cycle; a
                    // dropped request does not cancel the read in flight.
                    if (i_bram_done) begin
                        data_q  <= i_bram_data;
                        ack_q   <= req_onehot(gnt_q);
                        trig_q  <= 1'b0;
                        state_q <= RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        data_q  <= '0;
                        ack_q   <= req_onehot(gnt_q);
                        err_q   <= req_onehot(gnt_q);
                        trig_q  <= 1'b0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ack0      = ack_q[0];
    assign o_ack1      = ack_q[1];
    assign o_err0      = err_q[0];
    assign o_err1      = err_q[1];
    assign o_rd_data   = data_q;
    assign o_bram_addr = addr_q;
    assign o_bram_trig = trig_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter with a small BRAM model whose read
// latency is adjustable and whose done flag can be disabled.
`timescale 1ns/1ps
module tb_bram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [12:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, err0, err1, trig, busy;
    logic [31:0] rd_data, bram_data;
    logic [12:0] bram_addr;
    logic        bram_done;

    int          n_cmp = 0;
    int          n_bad = 0;

    // BRAM model controls
    logic        model_en = 1'b1;
    int          model_lat = 1;
    logic        stray = 1'b0;
    int          trig_cnt = 0;
    logic        done_q = 1'b0;
    logic [31:0] data_q = '0;

    always #5 clk = ~clk;

    bram_rd_arbiter #(.TIMEOUT_CYC(8)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_err0      (err0),
        .o_err1      (err1),
        .o_rd_data   (rd_data),
        .o_bram_addr (bram_addr),
        .o_bram_trig (trig),
        .i_bram_data (bram_data),
        .i_bram_done (bram_done),
        .o_busy      (busy)
    );

    function automatic logic [31:0] mem_rd(input logic [12:0] a);
        case (a)
            13'd0:   return 32'h1234_5678;
            13'd1:   return 32'h8765_4321;
            13'd2:   return 32'hCAFE_F00D;
            default: return 32'hA5A5_0000 | {19'h0, a};
        endcase
    endfunction

    // Done rises model_lat edges after the trigger is first sampled high.
    always @(posedge clk) begin
        done_q   <= model_en && trig && (trig_cnt == model_lat - 1);
        trig_cnt <= trig ? trig_cnt + 1 : 0;
        data_q   <= mem_rd(bram_addr);
    end

    assign bram_done = done_q | stray;
    assign bram_data = data_q;

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; stray = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Steps negedges until an ack is seen (bounded); counts trig-high cycles.
    task automatic run_until_ack(output int trig_cyc, output logic [1:0] acks,
                                 output logic [1:0] errs, output logic [31:0] data,
                                 output logic trig_at_ack, output logic hit);
        trig_cyc = 0; acks = '0; errs = '0; data = '0; trig_at_ack = 1'b0; hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                hit = 1'b1;
                acks = {ack1, ack0};
                errs = {err1, err0};
                data = rd_data;
                trig_at_ack = trig;
            end else if (trig) begin
                trig_cyc++;
            end
        end
        $display("txn: hit=%0b ack=%b err=%b data=%h trig_cycles=%0d", hit, acks, errs, data, trig_cyc);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({ack1, ack0, err1, err0, trig, busy, bram_addr, rd_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b%b err=%b%b trig=%b busy=%b addr=%h data=%h, want all 0",
                     ack1, ack0, err1, err0, trig, busy, bram_addr, rd_data);
        end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({trig, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: got trig=%b busy=%b, want 0 0", trig, busy);
        end
    endtask

    task automatic test_single_read();
        int tc; logic [1:0] a, e; logic [31:0] d; logic ta, h;
        do_reset();
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd0;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (!h) begin n_bad++; $display("FAIL single_timeout: no ack within bound, want ack0"); end
        n_cmp++;
        if (tc !== 2) begin n_bad++; $display("FAIL single_trig_len: got %0d, want 2", tc); end
        n_cmp++;
        if ({a, e, ta} !== 5'b01_00_0) begin
            n_bad++; $display("FAIL single_ack: got ack=%b err=%b trig=%b, want 01 00 0", a, e, ta);
        end
        n_cmp++;
        if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL single_data: got %h, want 12345678", d); end
        @(negedge clk);
        n_cmp++;
        if ({ack0, trig, busy} !== 3'b000 || rd_data !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL single_after: got ack0=%b trig=%b busy=%b data=%h, want 0 0 0 12345678",
                     ack0, trig, busy, rd_data);
        end
    endtask

    task automatic test_simultaneous();
        int tc; logic [1:0] a, e; logic [31:0] d; logic ta, h;
        do_reset();
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd0; req1 = 1'b1; addr1 = 13'd1;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (!h || a !== 2'b01 || d !== 32'h1234_5678) begin
            n_bad++; $display("FAIL simul_first: got hit=%b ack=%b data=%h, want 1 01 12345678", h, a, d);
        end
        @(negedge clk);
        n_cmp++;
        if (trig !== 1'b0) begin n_bad++; $display("FAIL simul_no_regrant: got trig=%b after release, want 0", trig); end
        @(negedge clk);
        n_cmp++;
        if ({trig, busy} !== 2'b11 || bram_addr !== 13'd1) begin
            n_bad++; $display("FAIL simul_second_issue: got trig=%b busy=%b addr=%h, want 1 1 0001", trig, busy, bram_addr);
        end
        run_until_ack(tc, a, e, d, ta, h);
        req1 = 1'b0;
        n_cmp++;
        if (!h || a !== 2'b10 || e !== 2'b00 || d !== 32'h8765_4321 || tc !== 1) begin
            n_bad++;
            $display("FAIL simul_second: got hit=%b ack=%b err=%b data=%h trig_rest=%0d, want 1 10 00 87654321 1",
                     h, a, e, d, tc);
        end
    endtask

    task automatic test_fairness();
        int tc; logic [1:0] a, e; logic [31:0] d; logic ta, h;
        logic [1:0] exp_ack [4];
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
        do_reset();
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd0; req1 = 1'b1; addr1 = 13'd1;
        for (int t = 0; t < 4; t++) begin
            run_until_ack(tc, a, e, d, ta, h);
            n_cmp++;
            if (!h || a !== exp_ack[t] || d !== (t % 2 == 0 ? 32'h1234_5678 : 32'h8765_4321)) begin
                n_bad++; $display("FAIL fair_txn%0d: got hit=%b ack=%b data=%h, want ack=%b", t, h, a, d, exp_ack[t]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int tc; logic [1:0] a, e; logic [31:0] d; logic ta, h;
        do_reset();
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd2;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL to_preload: got %h, want cafef00d", d); end
        // Done on the last allowed cycle: normal completion.
        model_lat = 7;
        @(negedge clk); req0 = 1'b1; addr0 = 13'd1;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (!h || tc !== 8 || a !== 2'b01 || e !== 2'b00 || d !== 32'h8765_4321) begin
            n_bad++;
            $display("FAIL to_done_on_edge: got hit=%b trig=%0d ack=%b err=%b data=%h, want 1 8 01 00 87654321",
                     h, tc, a, e, d);
        end
        // No done at all: abort after 8 ISSUE cycles.
        model_en = 1'b0;
        @(negedge clk); req0 = 1'b1; addr0 = 13'd0;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (!h || tc !== 8) begin n_bad++; $display("FAIL to_len: got hit=%b trig=%0d, want 1 8", h, tc); end
        n_cmp++;
        if ({a, e, ta} !== 5'b01_01_0 || d !== 32'h0) begin
            n_bad++; $display("FAIL to_abort: got ack=%b err=%b trig=%b data=%h, want 01 01 0 0", a, e, ta, d);
        end
        @(negedge clk);
        n_cmp++;
        if ({ack0, err0, trig} !== 3'b000) begin
            n_bad++; $display("FAIL to_pulse: got ack0=%b err0=%b trig=%b, want 0 0 0", ack0, err0, trig);
        end
        model_en = 1'b1; model_lat = 1;
    endtask

    task automatic test_mid_reset();
        int tc; logic [1:0] a, e; logic [31:0] d; logic ta, h;
        int seen;
        do_reset();
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd0;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        model_en = 1'b0;
        @(negedge clk); req0 = 1'b1; addr0 = 13'd1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (trig !== 1'b1) begin n_bad++; $display("FAIL mrst_pre: got trig=%b, want 1", trig); end
        #2; rstn = 1'b0; req0 = 1'b0;
        #1;
        n_cmp++;
        if ({ack1, ack0, err1, err0, trig, busy, bram_addr, rd_data} !== '0) begin
            n_bad++;
            $display("FAIL mrst_async: got ack=%b%b trig=%b busy=%b addr=%h data=%h, want all 0",
                     ack1, ack0, trig, busy, bram_addr, rd_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || trig) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL mrst_quiet: got %0d active cycles, want 0", seen); end
        model_en = 1'b1; model_lat = 1;
        req0 = 1'b1; addr0 = 13'd2;
        run_until_ack(tc, a, e, d, ta, h);
        req0 = 1'b0;
        n_cmp++;
        if (!h || tc !== 2 || a !== 2'b01 || e !== 2'b00 || d !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL mrst_recover: got hit=%b trig=%0d ack=%b err=%b data=%h, want 1 2 01 00 cafef00d",
                     h, tc, a, e, d);
        end
    endtask

    task automatic test_stray_done();
        do_reset();
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ack1, ack0, err1, err0, busy, trig} !== 6'b0 || rd_data !== 32'h0) begin
                n_bad++;
                $display("FAIL stray_%0d: got ack=%b%b busy=%b trig=%b data=%h, want idle zeros",
                         k, ack1, ack0, busy, trig, rd_data);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_mid_reset();
        test_stray_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
